filter_ctl: RTL
===============

FILTER_CTL -- requirements
Module: filter_ctl

Interface
REQ-001 Parameter FLT_OVH, default 1, output-FIFO words written per row in addition to the w residual words (filter-type word).
REQ-002 clk  input  1  single clock, rising edge.
REQ-003 rstn  input  1  asynchronous active-low reset.
REQ-004 cfg_w_i  input  SIZE_W_WD  frame width in pixels; sampled at frame start.
REQ-005 cfg_h_i  input  SIZE_H_WD  frame height in rows; sampled at frame start.
REQ-006 frm_start_i  input  1  one-cycle frame start request.
REQ-007 frm_done_o  output  1  one-cycle pulse when the frame ends.
REQ-008 busy_o  output  1  high from the accepted frm_start_i until frm_done_o, inclusive.
REQ-009 src_lvl_i  input  SIZE_W_WD+1  pixels available in the source FIFO.
REQ-010 dst_spc_i  input  SIZE_W_WD+1  free words in the filtered-output FIFO.
REQ-011 src_rd_val_o  output  1  source FIFO pop; also drives the filter datapath val_i.
REQ-012 flt_start_o  output  1  one-cycle row start to the filter datapath.
REQ-013 flt_done_i  input  1  row-done pulse from the filter datapath.
REQ-014 flt_cnt_h_i  input  SIZE_H_WD  filter datapath row counter.
REQ-015 bank_o  output  1  ping-pong previous-scanline buffer select.
REQ-016 row_cnt_o  output  SIZE_H_WD  index of the current row.
REQ-017 err_o  output  1  sticky error flag.

Function
REQ-018 FSM states: IDLE, CHK, KICK, OPT, WAIT, and no others.
REQ-019 IDLE->CHK on frm_start_i; the block registers cfg_w_i and cfg_h_i (w_r, h_r), clears row_cnt_o, clears err_o, and sets bank_o=0.
REQ-020 frm_start_i is ignored whenever busy_o=1.
REQ-021 If w_r=0 or h_r=0 at CHK: err_o<=1, frm_done_o pulses in that CHK cycle, and the FSM returns to IDLE with no flt_start_o.
REQ-022 CHK->KICK only when src_lvl_i>=w_r and dst_spc_i>=w_r+FLT_OVH; otherwise the FSM stays in CHK indefinitely.
REQ-023 KICK: flt_start_o=1 for exactly one cycle, then OPT.
REQ-024 OPT: src_rd_val_o=1 for exactly w_r consecutive cycles, counted by an internal SIZE_W_WD counter, then WAIT.
REQ-025 src_rd_val_o is never asserted outside OPT.
REQ-026 WAIT: on flt_done_i, if flt_cnt_h_i!=row_cnt_o then err_o<=1.
REQ-027 WAIT on flt_done_i, last row (row_cnt_o==h_r-1): frm_done_o pulses in that same cycle, row_cnt_o<=0, bank_o<=0, FSM->IDLE.
REQ-028 WAIT on flt_done_i, not last row: row_cnt_o<=row_cnt_o+1, bank_o toggles, FSM->CHK.
REQ-029 flt_done_i in any state other than WAIT sets err_o and is otherwise ignored.
REQ-030 err_o stays high until the next accepted frm_start_i or reset.
REQ-031 Minimum row period = w_r+3 cycles plus the datapath compare/final latency.
REQ-032 Level comparisons are unsigned at width SIZE_W_WD+1; w_r+FLT_OVH is computed at that width with no wrap for w_r<=2^SIZE_W_WD-1.
REQ-033 frm_done_o, flt_start_o and src_rd_val_o are combinational decodes of state and counters; all other outputs are registered.

Reset
REQ-034 rstn low asynchronously forces: state IDLE; frm_done_o, busy_o, src_rd_val_o, flt_start_o, bank_o, err_o all 0; row_cnt_o, w_r, h_r and the OPT counter all 0.
REQ-035 Reset mid-frame abandons the frame with no frm_done_o; after release the block waits in IDLE for a new frm_start_i.

Structure
REQ-036 SIZE_W_WD, SIZE_H_WD and the FSM state encoding (3-bit, IDLE=0) reside in the shared define/package file.
REQ-037 Single flat module; no sub-module is instantiated.

Verification
REQ-038 w=4, h=3, src_lvl=16, dst_spc=16, flt_done_i 5 cycles after OPT ends -> three flt_start_o pulses, 4 src_rd_val_o cycles per row, bank_o sequence 0,1,0, one frm_done_o, err_o=0.
REQ-039 w=8, dst_spc_i=8 (<9) held for 20 cycles, then 9 -> FSM stays in CHK with no flt_start_o, KICK follows the cycle after the condition becomes true.
REQ-040 cfg_w_i=0, h=2 -> frm_done_o one cycle after start, err_o=1, no flt_start_o, no src_rd_val_o.
REQ-041 flt_cnt_h_i=1 on the first row's done -> err_o=1 and the frame still completes normally.
REQ-042 Second frm_start_i issued during OPT -> ignored (row_cnt_o and w_r unchanged).
REQ-043 rstn low during OPT of row 1 -> all outputs 0 immediately; a new frame w=2, h=1 afterward completes with bank_o=0.

Source files
------------

// File: rtl/filter_ctl_pkg.sv
// Shared sizes and FSM state encoding for the filter row controller.
package filter_ctl_pkg;

  localparam int unsigned SIZE_W_WD = 10;
  localparam int unsigned SIZE_H_WD = 10;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_CHK  = 3'd1,
    ST_KICK = 3'd2,
    ST_OPT  = 3'd3,
    ST_WAIT = 3'd4
  } state_e;

endpackage

// File: rtl/filter_ctl.sv
// Row sequencer for the filter datapath: checks FIFO headroom, kicks each row,
// streams w pixels from the source FIFO and tracks row/bank/error state per frame.
module filter_ctl
  import filter_ctl_pkg::*;
#(
  parameter int unsigned FLT_OVH = 1
) (
  input  logic                 clk,
  input  logic                 rstn,
  input  logic [SIZE_W_WD-1:0] cfg_w_i,
  input  logic [SIZE_H_WD-1:0] cfg_h_i,
  input  logic                 frm_start_i,
  output logic                 frm_done_o,
  output logic                 busy_o,
  input  logic [SIZE_W_WD:0]   src_lvl_i,
  input  logic [SIZE_W_WD:0]   dst_spc_i,
  output logic                 src_rd_val_o,
  output logic                 flt_start_o,
  input  logic                 flt_done_i,
  input  logic [SIZE_H_WD-1:0] flt_cnt_h_i,
  output logic                 bank_o,
  output logic [SIZE_H_WD-1:0] row_cnt_o,
  output logic                 err_o
);

  state_e               state_q, state_d;
  logic [SIZE_W_WD-1:0] w_q, w_d;
  logic [SIZE_H_WD-1:0] h_q, h_d;
  logic [SIZE_H_WD-1:0] row_q, row_d;
  logic [SIZE_W_WD-1:0] opt_cnt_q, opt_cnt_d;
  logic                 bank_q, bank_d;
  logic                 err_q, err_d;
  logic                 busy_q, busy_d;
  logic                 frm_done, flt_start, src_rd_val;
  logic [SIZE_W_WD:0]   need_spc;
  logic                 last_row;

  // One extra bit keeps w + overhead from wrapping at the maximum width.
  assign need_spc = {1'b0, w_q} + (SIZE_W_WD + 1)'(FLT_OVH);
  assign last_row = (row_q == h_q - SIZE_H_WD'(1));

  always_comb begin
    state_d    = state_q;
    w_d        = w_q;
    h_d        = h_q;
    row_d      = row_q;
    opt_cnt_d  = opt_cnt_q;
    bank_d     = bank_q;
    err_d      = err_q;
    busy_d     = busy_q;
    frm_done   = 1'b0;
    flt_start  = 1'b0;
    src_rd_val = 1'b0;

    unique case (state_q)
      ST_IDLE: begin
        if (frm_start_i) begin
          w_d       = cfg_w_i;
          h_d       = cfg_h_i;
          row_d     = '0;
          opt_cnt_d = '0;
          bank_d    = 1'b0;
          err_d     = 1'b0;
          state_d   = ST_CHK;
        end
      end
      ST_CHK: begin
        if (w_q == '0 || h_q == '0) begin
          err_d    = 1'b1;
          frm_done = 1'b1;
          state_d  = ST_IDLE;
        end else if (src_lvl_i >= {1'b0, w_q} && dst_spc_i >= need_spc) begin
          state_d = ST_KICK;
        end
      end
      ST_KICK: begin
        flt_start = 1'b1;
        state_d   = ST_OPT;
      end
      ST_OPT: begin
        src_rd_val = 1'b1;
        if (opt_cnt_q == w_q - SIZE_W_WD'(1)) begin
          opt_cnt_d = '0;
          state_d   = ST_WAIT;
        end else begin
          opt_cnt_d = opt_cnt_q + SIZE_W_WD'(1);
        end
      end
      ST_WAIT: begin
        if (flt_done_i) begin
          if (flt_cnt_h_i != row_q) err_d = 1'b1;
          if (last_row) begin
            frm_done = 1'b1;
            row_d    = '0;
            bank_d   = 1'b0;
            state_d  = ST_IDLE;
          end else begin
            row_d   = row_q + SIZE_H_WD'(1);
            bank_d  = ~bank_q;
            state_d = ST_CHK;
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase

    // A row-done outside WAIT is a protocol error; it overrides the clear on start.
    if (flt_done_i && state_q != ST_WAIT) err_d = 1'b1;

    busy_d = (state_d != ST_IDLE);
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q   <= ST_IDLE;
      w_q       <= '0;
      h_q       <= '0;
      row_q     <= '0;
      opt_cnt_q <= '0;
      bank_q    <= 1'b0;
      err_q     <= 1'b0;
      busy_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      w_q       <= w_d;
      h_q       <= h_d;
      row_q     <= row_d;
      opt_cnt_q <= opt_cnt_d;
      bank_q    <= bank_d;
      err_q     <= err_d;
      busy_q    <= busy_d;
    end
  end

  assign frm_done_o   = frm_done;
  assign flt_start_o  = flt_start;
  assign src_rd_val_o = src_rd_val;
  assign busy_o       = busy_q;
  assign bank_o       = bank_q;
  assign row_cnt_o    = row_q;
  assign err_o        = err_q;

endmodule
